// File: rtl/tx_fifo_reader_pkg.sv
// Shared types and defaults for the transmit FIFO reader.
package tx_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CLKS_PER_BIT = 16;
  localparam int unsigned STOP_BITS    = 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLoad,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Cycles a frame occupies on the line, start bit through last stop bit.
  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned clks_per_bit,
                                               input int unsigned stop_bits);
    return (1 + data_w + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/tx_fifo_reader_if.sv
// FIFO read port plus serial line and status signals of the transmit reader.
interface tx_fifo_reader_if #(
  parameter int unsigned DATA_W = tx_pkg::DATA_W
);

  logic              Tx_Enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_rdreq;
  logic              tx_serial;
  logic              tx_busy;
  logic              Frame_Done;

  modport master (
    input  Tx_Enable,
    input  fifo_empty,
    input  fifo_q,
    output fifo_rdreq,
    output tx_serial,
    output tx_busy,
    output Frame_Done
  );

  modport slave (
    output Tx_Enable,
    output fifo_empty,
    output fifo_q,
    input  fifo_rdreq,
    input  tx_serial,
    input  tx_busy,
    input  Frame_Done
  );

endinterface

// File: rtl/tx_fifo_reader_bit_timer.sv
// Free-running cycle counter that ticks on the cycle its count equals last_i, then restarts.
module bit_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [CntW-1:0] last_i,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_fifo_reader.sv
// Pops one FIFO word per frame and shifts it out as start bit, LSB-first data, stop bit(s).
module tx_fifo_reader #(
  parameter int unsigned DATA_W       = tx_pkg::DATA_W,
  parameter int unsigned CLKS_PER_BIT = tx_pkg::CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = tx_pkg::STOP_BITS
) (
  input logic              Mclk,
  input logic              Reset,
  tx_fifo_reader_if.master bus
);

  import tx_pkg::*;

  localparam int unsigned CntW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_W + 1);

  // Terminal values are stored as "last count" so they always fit the counter width.
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic              timer_clear;
  logic [CntW-1:0]   timer_last;

  assign timer_clear = (state_q == StIdle) || (state_q == StReq) || (state_q == StLoad);
  assign timer_last  = (state_q == StStop) ? StopLast : BitLast;

  bit_timer #(
    .CntW(CntW)
  ) u_bit_timer (
    .clk_i  (Mclk),
    .rst_i  (Reset),
    .clear_i(timer_clear),
    .last_i (timer_last),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!bus.fifo_empty && bus.Tx_Enable) begin
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = StReq;
        end
      end
      // FIFO samples rdreq on this edge; fifo_q is valid during LOAD.
      StReq: state_d = StLoad;
      StLoad: begin
        shift_d = bus.fifo_q;
        tx_d    = 1'b0;
        bit_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LastBit) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      StStop: begin
        if (tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Mclk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.fifo_rdreq = rd_q;
  assign bus.tx_serial  = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.Frame_Done = done_q;

endmodule

// File: tb/tb_tx_fifo_reader.sv
// Randomised and directed bench for tx_fifo_reader against a frame-timeline model.
module tb_tx_fifo_reader;
  import tx_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned CPB  = 4;
  localparam int unsigned SB   = 1;
  localparam int          FC   = int'(frame_cycles(DW, CPB, SB));
  localparam int          HMAX = 16384;

  logic Mclk = 1'b0;
  logic Reset;

  tx_fifo_reader_if #(.DATA_W(DW)) bus ();

  tx_fifo_reader #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .Mclk (Mclk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Mclk = ~Mclk;

  logic [DW-1:0] fifo[$];
  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic h_rd[HMAX];
  logic h_done[HMAX];
  logic h_busy[HMAX];
  logic h_tx[HMAX];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)",
               name, cyc, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Mclk);
    #1;
  endtask

  // Non-show-ahead FIFO: a sampled rdreq pops the head onto fifo_q.
  initial begin : fifo_model
    logic pop;
    bus.fifo_empty = 1'b1;
    bus.fifo_q     = '0;
    forever begin
      @(posedge Mclk);
      pop = bus.fifo_rdreq;
      #2;
      if (pop === 1'b1 && fifo.size() > 0) bus.fifo_q = fifo.pop_front();
      bus.fifo_empty = (fifo.size() == 0);
    end
  end

  // Reference: a frame is a timeline indexed by cycles since the starting edge.
  bit          m_act  = 1'b0;
  bit          m_done = 1'b0;
  int          m_t    = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge Mclk or posedge Reset) begin
    if (Reset) begin
      m_act  = 1'b0;
      m_done = 1'b0;
      m_t    = 0;
    end else if (m_act) begin
      m_t++;
      if (m_t == FC + 2) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (bus.fifo_empty === 1'b0 && bus.Tx_Enable === 1'b1 && fifo.size() > 0) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_data = fifo[0];
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!(m_act || m_done)) return 1'b1;
    if (m_t < 2) return 1'b1;
    b = (m_t - 2) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return m_data[b-1];
    return 1'b1;
  endfunction

  always @(negedge Mclk) begin
    chk("tx_serial", {31'b0, bus.tx_serial}, {31'b0, exp_tx()});
    chk("tx_busy", {31'b0, bus.tx_busy}, {31'b0, m_act});
    chk("Frame_Done", {31'b0, bus.Frame_Done}, {31'b0, m_done});
    chk("fifo_rdreq", {31'b0, bus.fifo_rdreq}, {31'b0, (m_act && m_t == 0)});
    if (cyc < HMAX) begin
      h_rd[cyc]   = bus.fifo_rdreq;
      h_done[cyc] = bus.Frame_Done;
      h_busy[cyc] = bus.tx_busy;
      h_tx[cyc]   = bus.tx_serial;
    end
    cyc++;
  end

  // which: 0 rdreq, 1 Frame_Done, 2 tx_busy, 3 tx_serial low
  function automatic logic hist(input int which, input int i);
    if (i < 0 || i >= HMAX) return 1'b0;
    case (which)
      0: return h_rd[i];
      1: return h_done[i];
      2: return h_busy[i];
      default: return !h_tx[i];
    endcase
  endfunction

  function automatic int count_h(input int which, input int s, input int e);
    int n = 0;
    for (int i = s; i < e; i++) if (hist(which, i) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_h(input int which, input int s, input int e);
    for (int i = s; i < e; i++) if (hist(which, i) === 1'b1) return i;
    return -1;
  endfunction

  // Mid-bit samples of start, data and stop bits, start bit in bit 0.
  function automatic logic [9:0] bits_of(input int fall);
    logic [9:0] v;
    for (int k = 0; k < 10; k++) begin
      v[k] = (fall + 4 * k + 1 < HMAX && fall >= 0) ? h_tx[fall + 4 * k + 1] : 1'bx;
    end
    return v;
  endfunction

  function automatic logic [9:0] frame_bits(input logic [DW-1:0] w);
    return {1'b1, w, 1'b0};
  endfunction

  task automatic wait_fall(output int waited);
    waited = 0;
    while (bus.tx_serial !== 1'b0 && waited < 20) begin
      tick(1);
      waited++;
    end
  endtask

  initial begin : main
    int s, s2, e, rd1, f1, f2, d1, d2, w, rd_c, dn_c;
    Reset         = 1'b1;
    bus.Tx_Enable = 1'b0;
    #1;
    chk("reset_tx_serial", {31'b0, bus.tx_serial}, 32'd1);
    chk("reset_rdreq", {31'b0, bus.fifo_rdreq}, 32'd0);
    chk("reset_busy", {31'b0, bus.tx_busy}, 32'd0);
    chk("reset_done", {31'b0, bus.Frame_Done}, 32'd0);
    tick(2);
    Reset = 1'b0;

    // Single word 0xA5
    s = cyc;
    fifo.push_back(8'hA5);
    bus.Tx_Enable = 1'b1;
    tick(60);
    e   = cyc;
    rd1 = first_h(0, s, e);
    f1  = first_h(3, s, e);
    d1  = first_h(1, s, e);
    chk("single_rdreq_count", count_h(0, s, e), 32'd1);
    chk("single_events_seen", {31'b0, (rd1 >= 0 && f1 >= 0 && d1 >= 0)}, 32'd1);
    chk("single_rdreq_to_start", f1 - rd1, 32'd2);
    chk("single_start_to_done", d1 - f1, 32'd40);
    chk("single_busy_span", count_h(2, s, e), 32'd42);
    chk("single_bits_a5", {22'b0, bits_of(f1)}, {22'b0, 10'b1101001010});

    // Empty FIFO
    s = cyc;
    tick(200);
    e = cyc;
    chk("empty_rdreq", count_h(0, s, e), 32'd0);
    chk("empty_tx_low", count_h(3, s, e), 32'd0);
    chk("empty_busy", count_h(2, s, e), 32'd0);

    // Back-to-back 0x00, 0xFF
    s = cyc;
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    tick(120);
    e  = cyc;
    f1 = first_h(3, s, e);
    f2 = first_h(3, f1 + FC, e);
    d1 = first_h(1, s, e);
    d2 = first_h(1, d1 + 1, e);
    chk("b2b_rdreq_count", count_h(0, s, e), 32'd2);
    chk("b2b_frame1_len", d1 - f1, 32'd40);
    chk("b2b_frame2_len", d2 - f2, 32'd40);
    chk("b2b_gap", f2 - (f1 + FC), 32'd3);
    chk("b2b_bits_00", {22'b0, bits_of(f1)}, {22'b0, 10'b1000000000});
    chk("b2b_bits_ff", {22'b0, bits_of(f2)}, {22'b0, 10'b1111111110});

    // Tx_Enable dropped mid-frame
    s = cyc;
    fifo.push_back(8'h3C);
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    wait_fall(w);
    chk("en_drop_start_seen", {31'b0, (w < 20)}, 32'd1);
    tick(10);
    bus.Tx_Enable = 1'b0;
    tick(100);
    e = cyc;
    chk("en_drop_rdreq_count", count_h(0, s, e), 32'd1);
    chk("en_drop_done_count", count_h(1, s, e), 32'd1);
    chk("en_drop_left_queued", fifo.size(), 32'd2);
    chk("en_drop_bits_3c", {22'b0, bits_of(first_h(3, s, e))}, {22'b0, frame_bits(8'h3C)});
    bus.Tx_Enable = 1'b1;
    tick(100);
    chk("en_drop_drained", fifo.size(), 32'd0);

    // Reset at cycle 17 of a 0x81 frame
    s = cyc;
    fifo.push_back(8'h81);
    fifo.push_back(8'h55);
    wait_fall(w);
    tick(17);
    Reset = 1'b1;
    #1;
    chk("midreset_tx_serial", {31'b0, bus.tx_serial}, 32'd1);
    chk("midreset_busy", {31'b0, bus.tx_busy}, 32'd0);
    chk("midreset_rdreq", {31'b0, bus.fifo_rdreq}, 32'd0);
    chk("midreset_done", {31'b0, bus.Frame_Done}, 32'd0);
    @(posedge Mclk);
    #1;
    Reset = 1'b0;
    s2 = cyc;
    tick(100);
    e = cyc;
    chk("midreset_done_count", count_h(1, s, e), 32'd1);
    chk("midreset_rdreq_after", count_h(0, s2, e), 32'd1);
    chk("midreset_bits_55", {22'b0, bits_of(first_h(3, s2, e))}, {22'b0, frame_bits(8'h55)});

    // Reset while in REQ
    fifo.push_back(8'h5A);
    fifo.push_back(8'h33);
    w = 0;
    while (bus.fifo_rdreq !== 1'b1 && w < 10) begin
      tick(1);
      w++;
    end
    chk("reqreset_rdreq_seen", {31'b0, (w < 10)}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("reqreset_rdreq_cleared", {31'b0, bus.fifo_rdreq}, 32'd0);
    chk("reqreset_busy_cleared", {31'b0, bus.tx_busy}, 32'd0);
    @(posedge Mclk);
    #1;
    Reset = 1'b0;
    s = cyc;
    tick(150);
    e    = cyc;
    rd_c = count_h(0, s, e);
    dn_c = count_h(1, s, e);
    chk("reqreset_one_rdreq_per_frame", rd_c, dn_c);
    chk("reqreset_drained", fifo.size(), 32'd0);

    // Randomised traffic, enable toggling and occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0 && fifo.size() < 4) fifo.push_back(DW'($urandom));
      if ($urandom_range(0, 63) == 0) bus.Tx_Enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 799) == 0) begin
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
      end
      tick(1);
    end
    bus.Tx_Enable = 1'b1;
    tick(300);
    chk("random_drained", fifo.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
